program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side counterpart of the CPU instruction decoder.
- Accepts field-level instruction commands over a valid/ready handshake and encodes each into the 13-bit instruction word the decoder consumes.
- Writes the words sequentially into the 256-entry program memory and holds the CPU in reset while loading.
- Sits between the host/UART command path and the program memory write port.

Parameters:
- DEPTH, 256, program memory entries; must be ≤256 (branch target is 8 bits)
- FILL_NOP, 1, when 1, pad unwritten addresses after the last command with NOP words

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- start_i  in  1  begin a load session (sampled in IDLE/DONE only)
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  loader can accept a command
- cmd_kind_i  in  2  00 ALU, 01 BRANCH, 10 LDI, 11 NOP
- cmd_alu_op_i  in  3  ALU opcode
- cmd_src_a_i  in  3  operand A register
- cmd_src_b_i  in  3  operand B register
- cmd_dest_i  in  3  destination register
- cmd_imm_i  in  8  branch target (BRANCH) or immediate (LDI, low 6 bits legal)
- cmd_last_i  in  1  this is the final command of the program
- mem_wr_en_o  out  1  program memory write strobe
- mem_addr_o  out  8  program memory write address
- mem_data_o  out  13  encoded instruction word
- cpu_hold_o  out  1  holds the CPU in reset while loading
- done_o  out  1  load complete
- error_o  out  1  sticky error for the session
- count_o  out  9  number of commands written in the session

Behaviour:
- Reset (rst_n_i=0 at a clock edge, from any state, including mid-load):
  - State → IDLE.
  - All outputs 0: cmd_ready_o, mem_wr_en_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o, count_o.
- Encoding (registered into mem_data_o on command accept):
  - ALU: {1'b0, alu_op[2:0], src_a[2:0], src_b[2:0], dest[2:0]}.
  - BRANCH: {3'b100, 2'b00, imm[7:0]}.
  - LDI: {4'b1010, imm[5:0], dest[2:0]}. If imm[7:6]≠0, error_o is set and the truncated word is still written.
  - NOP: 13'b1_0110_0000_0000 (class 1011; no register write, no branch).
- FSM states: IDLE, LOAD, WRITE, FILL, DONE.
- IDLE:
  - cpu_hold_o=0, cmd_ready_o=0.
  - start_i=1 → LOAD; address pointer=0, count_o=0, error_o=0, cpu_hold_o=1.
- LOAD:
  - cmd_ready_o=1, cpu_hold_o=1.
  - When cmd_valid_i && cmd_ready_o: latch the encoded word and cmd_last_i → WRITE.
  - Without valid, stay in LOAD; no timeout.
- WRITE (exactly one cycle):
  - mem_wr_en_o=1, mem_addr_o=pointer, mem_data_o=encoded word, cmd_ready_o=0.
  - Next-state priority:
    1. last latched and FILL_NOP=1 and pointer<DEPTH-1 → FILL, pointer+1.
    2. last latched → DONE.
    3. pointer==DEPTH-1 (memory full, not last) → set error_o → DONE.
    4. Otherwise → LOAD, pointer+1.
  - count_o increments on each WRITE.
- FILL:
  - mem_wr_en_o=1 each cycle, mem_data_o=NOP, address incrementing.
  - Exits to DONE after writing address DEPTH-1.
  - count_o does not increment.
- DONE:
  - done_o=1, cpu_hold_o=0, cmd_ready_o=0.
  - Holds until start_i=1 → LOAD; that clears done_o, error_o and count_o and re-asserts cpu_hold_o.
- Latency and throughput:
  - Command accepted at edge N → write strobe visible in cycle N+1.
  - Maximum throughput is one command per 2 cycles.
- start_i is ignored in LOAD, WRITE and FILL.
- mem_wr_en_o is never asserted outside WRITE/FILL. The address pointer never wraps.

Test Plan:
- Reset then start_i → cpu_hold_o=1, cmd_ready_o=1. ALU cmd (op=3, a=1, b=2, dest=4) → one cycle of mem_wr_en_o with addr 0, data 13'b0_011_001_010_100.
- BRANCH imm=8'hA5 with last=1, FILL_NOP=0 → addr 0, data 13'h10A5. Then done_o=1, cpu_hold_o=0, count_o=1.
- LDI imm=8'h4F, dest=2 → data {1010, 001111, 010}, error_o=1, load continues normally.
- 3 commands with last on the third, FILL_NOP=1, DEPTH=8 → writes at addr 0-2 are the commands, addr 3-7 are NOP 13'h1600. done_o=1, count_o=3.
- DEPTH=4, 4 commands with none marked last → 4 writes, then error_o=1 and done_o=1. A 5th cmd_valid_i sees cmd_ready_o=0.
- rst_n_i=0 during LOAD after 2 writes → next cycle all outputs 0, state IDLE. cmd_valid_i is ignored until start_i.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: encodes host instruction commands into 13-bit decoder words and
// writes them sequentially into program memory while holding the CPU in reset.
module program_loader #(
   parameter int DEPTH    = 256,
   parameter int FILL_NOP = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_kind_i,
   input  logic [2:0]  cmd_alu_op_i,
   input  logic [2:0]  cmd_src_a_i,
   input  logic [2:0]  cmd_src_b_i,
   input  logic [2:0]  cmd_dest_i,
   input  logic [7:0]  cmd_imm_i,
   input  logic        cmd_last_i,
   output logic        mem_wr_en_o,
   output logic [7:0]  mem_addr_o,
   output logic [12:0] mem_data_o,
   output logic        cpu_hold_o,
   output logic        done_o,
   output logic        error_o,
   output logic [8:0]  count_o
);

   localparam logic [7:0]  LAST_ADDR = 8'(DEPTH - 1);
   localparam logic [12:0] NOP_WORD  = 13'h1600;
   localparam logic [1:0]  K_ALU     = 2'b00;
   localparam logic [1:0]  K_BRANCH  = 2'b01;
   localparam logic [1:0]  K_LDI     = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_FILL, S_DONE} state_t;

   state_t      r_state;
   logic        r_last;
   logic        r_ready;
   logic        r_wr_en;
   logic [7:0]  r_ptr;
   logic [12:0] r_data;
   logic        r_hold;
   logic        r_done;
   logic        r_error;
   logic [8:0]  r_count;

   logic [12:0] w_word;
   logic        w_ldi_bad;
   logic        w_accept;

   function automatic logic [12:0] f_encode(
      input logic [1:0] kind,
      input logic [2:0] op,
      input logic [2:0] src_a,
      input logic [2:0] src_b,
      input logic [2:0] dest,
      input logic [7:0] imm
   );
      logic [12:0] word;
      case (kind)
         K_ALU:    word = {1'b0, op, src_a, src_b, dest};
         K_BRANCH: word = {3'b100, 2'b00, imm};
         K_LDI:    word = {4'b1010, imm[5:0], dest};
         default:  word = NOP_WORD;
      endcase
      return word;
   endfunction

   assign w_word    = f_encode(cmd_kind_i, cmd_alu_op_i, cmd_src_a_i, cmd_src_b_i,
                               cmd_dest_i, cmd_imm_i);
   // LDI immediates are 6 bits wide; anything in the top two bits is lost.
   assign w_ldi_bad = (cmd_kind_i == K_LDI) && (cmd_imm_i[7:6] != 2'b00);
   assign w_accept  = cmd_valid_i && r_ready;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_last  <= 1'b0;
         r_ready <= 1'b0;
         r_wr_en <= 1'b0;
         r_ptr   <= 8'd0;
         r_data  <= 13'd0;
         r_hold  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_count <= 9'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  r_state <= S_LOAD;
                  r_ptr   <= 8'd0;
                  r_count <= 9'd0;
                  r_error <= 1'b0;
                  r_done  <= 1'b0;
                  r_hold  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_state <= S_WRITE;
                  r_data  <= w_word;
                  r_last  <= cmd_last_i;
                  r_wr_en <= 1'b1;
                  r_ready <= 1'b0;
                  r_count <= r_count + 9'd1;
                  if (w_ldi_bad) r_error <= 1'b1;
               end
            end
            S_WRITE: begin
               if (r_last && (FILL_NOP != 0) && (r_ptr < LAST_ADDR)) begin
                  r_state <= S_FILL;
                  r_ptr   <= r_ptr + 8'd1;
                  r_data  <= NOP_WORD;
               end else if (r_last || (r_ptr == LAST_ADDR)) begin
                  // Running out of memory before the last command is a session error.
                  if (!r_last) r_error <= 1'b1;
                  r_state <= S_DONE;
                  r_wr_en <= 1'b0;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
               end else begin
                  r_state <= S_LOAD;
                  r_ptr   <= r_ptr + 8'd1;
                  r_wr_en <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            S_FILL: begin
               if (r_ptr == LAST_ADDR) begin
                  r_state <= S_DONE;
                  r_wr_en <= 1'b0;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = r_ready;
   assign mem_wr_en_o = r_wr_en;
   assign mem_addr_o  = r_ptr;
   assign mem_data_o  = r_data;
   assign cpu_hold_o  = r_hold;
   assign done_o      = r_done;
   assign error_o     = r_error;
   assign count_o     = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: three instances (DEPTH/FILL_NOP variants) sharing stimulus,
// a vector table, hand sequences for multi-cycle corners, and random sessions vs a model.
module tb_program_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, cmd_valid, cmd_last;
   logic [1:0] kind;
   logic [2:0] op, sa, sb, dst;
   logic [7:0] imm;

   logic        rdy[3], wen[3], hold[3], dn[3], err[3];
   logic [7:0]  addr[3];
   logic [12:0] data[3];
   logic [8:0]  cnt[3];

   program_loader #(.DEPTH(256), .FILL_NOP(0)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cmd_valid_i(cmd_valid),
      .cmd_ready_o(rdy[0]), .cmd_kind_i(kind), .cmd_alu_op_i(op), .cmd_src_a_i(sa),
      .cmd_src_b_i(sb), .cmd_dest_i(dst), .cmd_imm_i(imm), .cmd_last_i(cmd_last),
      .mem_wr_en_o(wen[0]), .mem_addr_o(addr[0]), .mem_data_o(data[0]),
      .cpu_hold_o(hold[0]), .done_o(dn[0]), .error_o(err[0]), .count_o(cnt[0]));

   program_loader #(.DEPTH(8), .FILL_NOP(1)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cmd_valid_i(cmd_valid),
      .cmd_ready_o(rdy[1]), .cmd_kind_i(kind), .cmd_alu_op_i(op), .cmd_src_a_i(sa),
      .cmd_src_b_i(sb), .cmd_dest_i(dst), .cmd_imm_i(imm), .cmd_last_i(cmd_last),
      .mem_wr_en_o(wen[1]), .mem_addr_o(addr[1]), .mem_data_o(data[1]),
      .cpu_hold_o(hold[1]), .done_o(dn[1]), .error_o(err[1]), .count_o(cnt[1]));

   program_loader #(.DEPTH(4), .FILL_NOP(0)) u2 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cmd_valid_i(cmd_valid),
      .cmd_ready_o(rdy[2]), .cmd_kind_i(kind), .cmd_alu_op_i(op), .cmd_src_a_i(sa),
      .cmd_src_b_i(sb), .cmd_dest_i(dst), .cmd_imm_i(imm), .cmd_last_i(cmd_last),
      .mem_wr_en_o(wen[2]), .mem_addr_o(addr[2]), .mem_data_o(data[2]),
      .cpu_hold_o(hold[2]), .done_o(dn[2]), .error_o(err[2]), .count_o(cnt[2]));

   typedef struct {int kind; int op; int a; int b; int d; int imm;} cmd_t;
   typedef struct {cmd_t c; int exp_data; int exp_err;} vec_t;
   typedef struct {int k; int a; int d;} wr_t;

   int  n_vec = 0;
   int  n_bad = 0;
   wr_t wlog[$];
   wr_t exp_q[$];
   wr_t got_q[$];

   always @(negedge clk)
      for (int k = 0; k < 3; k++)
         if (wen[k]) wlog.push_back('{k: k, a: int'(addr[k]), d: int'(data[k])});

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Instruction word derived arithmetically from the field layout.
   function automatic int ref_word(input cmd_t c);
      case (c.kind)
         0:       return c.op * 512 + c.a * 64 + c.b * 8 + c.d;
         1:       return 4096 + c.imm;
         2:       return 5120 + (c.imm % 64) * 8 + c.d;
         default: return 5632;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", rdy[k], 0); chk("rst_wen", wen[k], 0);
         chk("rst_addr", addr[k], 0); chk("rst_data", data[k], 0);
         chk("rst_hold", hold[k], 0); chk("rst_done", dn[k], 0);
         chk("rst_err", err[k], 0);   chk("rst_count", cnt[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wlog.delete();
   endtask

   task automatic send(input int t, input cmd_t c, input bit last, output bit ok);
      int w;
      @(negedge clk);
      kind = 2'(c.kind); op = 3'(c.op); sa = 3'(c.a); sb = 3'(c.b);
      dst = 3'(c.d); imm = 8'(c.imm); cmd_last = last; cmd_valid = 1'b1;
      w = 0;
      while (!rdy[t] && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!rdy[t]) begin
         n_vec++; n_bad++;
         $display("FAIL handshake dut%0d: ready stuck at 0, expected 1", t);
         cmd_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic wait_done(input int t, input int bound);
      int i;
      i = 0;
      while (!dn[t] && i < bound) begin
         @(posedge clk); #1;
         i++;
      end
      chk("done_reached", dn[t], 1);
   endtask

   task automatic compare_log(input int t);
      got_q.delete();
      foreach (wlog[j]) if (wlog[j].k == t) got_q.push_back(wlog[j]);
      chk("write_count", got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         chk("write_addr", got_q[j].a, exp_q[j].a);
         chk("write_data", got_q[j].d, exp_q[j].d);
      end
   endtask

   vec_t tbl[8];
   bit   ok;

   initial begin
      rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
      kind = '0; op = '0; sa = '0; sb = '0; dst = '0; imm = '0;

      tbl[0] = '{'{0, 3, 1, 2, 4, 8'h00}, 'h0654, 0};
      tbl[1] = '{'{1, 7, 7, 7, 7, 8'hA5}, 'h10A5, 0};
      tbl[2] = '{'{2, 5, 3, 1, 2, 8'h4F}, 'h147A, 1};
      tbl[3] = '{'{3, 5, 5, 5, 5, 8'hFF}, 'h1600, 1};
      tbl[4] = '{'{2, 0, 0, 0, 7, 8'h3F}, 'h15FF, 1};
      tbl[5] = '{'{0, 7, 7, 7, 7, 8'hFF}, 'h0FFF, 1};
      tbl[6] = '{'{1, 0, 0, 0, 0, 8'h00}, 'h1000, 1};
      tbl[7] = '{'{0, 0, 0, 0, 0, 8'h00}, 'h0000, 1};

      // Vector table on DEPTH=256, FILL_NOP=0.
      do_reset();
      do_start();
      chk("start_hold", hold[0], 1);
      chk("start_ready", rdy[0], 1);
      for (int i = 0; i < 8; i++) begin
         send(0, tbl[i].c, i == 7, ok);
         chk("tbl_wen", wen[0], 1);
         chk("tbl_addr", addr[0], i);
         chk("tbl_data", data[0], tbl[i].exp_data);
         chk("tbl_err", err[0], tbl[i].exp_err);
         chk("tbl_ready", rdy[0], 0);
      end
      @(posedge clk); #1;
      chk("tbl_done", dn[0], 1);
      chk("tbl_hold", hold[0], 0);
      chk("tbl_count", cnt[0], 8);
      chk("tbl_wen_off", wen[0], 0);

      // Single BRANCH marked last, no fill.
      do_reset();
      do_start();
      send(0, '{1, 0, 0, 0, 0, 8'hA5}, 1'b1, ok);
      chk("br_addr", addr[0], 0);
      chk("br_data", data[0], 'h10A5);
      @(posedge clk); #1;
      chk("br_done", dn[0], 1);
      chk("br_hold", hold[0], 0);
      chk("br_count", cnt[0], 1);

      // Three commands then NOP fill up to DEPTH-1 on DEPTH=8.
      do_reset();
      do_start();
      send(1, '{0, 1, 2, 3, 4, 0}, 1'b0, ok);
      send(1, '{2, 0, 0, 0, 5, 8'h21}, 1'b0, ok);
      send(1, '{1, 0, 0, 0, 0, 8'h7E}, 1'b1, ok);
      wait_done(1, 20);
      exp_q.delete();
      exp_q.push_back('{k: 1, a: 0, d: 'h029C});
      exp_q.push_back('{k: 1, a: 1, d: 'h150D});
      exp_q.push_back('{k: 1, a: 2, d: 'h107E});
      for (int a = 3; a < 8; a++) exp_q.push_back('{k: 1, a: a, d: 'h1600});
      compare_log(1);
      chk("fill_count", cnt[1], 3);
      chk("fill_err", err[1], 0);

      // Memory full without a last command on DEPTH=4.
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) send(2, '{0, i, i, i, i, 0}, 1'b0, ok);
      @(posedge clk); #1;
      chk("full_err", err[2], 1);
      chk("full_done", dn[2], 1);
      chk("full_count", cnt[2], 4);
      chk("full_hold", hold[2], 0);
      @(negedge clk);
      cmd_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("full_ready", rdy[2], 0);
      got_q.delete();
      foreach (wlog[j]) if (wlog[j].k == 2) got_q.push_back(wlog[j]);
      chk("full_writes", got_q.size(), 4);
      cmd_valid = 1'b0;
      do_start();
      chk("restart_err", err[2], 0);
      chk("restart_done", dn[2], 0);
      chk("restart_count", cnt[2], 0);
      chk("restart_hold", hold[2], 1);
      chk("restart_ready", rdy[2], 1);

      // Reset in the middle of a load.
      do_reset();
      do_start();
      send(0, '{0, 1, 1, 1, 1, 0}, 1'b0, ok);
      send(0, '{3, 0, 0, 0, 0, 0}, 1'b0, ok);
      @(posedge clk); #1;
      chk("mid_ready", rdy[0], 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_ready0", rdy[0], 0); chk("mid_wen0", wen[0], 0);
      chk("mid_addr0", addr[0], 0); chk("mid_data0", data[0], 0);
      chk("mid_hold0", hold[0], 0); chk("mid_done0", dn[0], 0);
      chk("mid_err0", err[0], 0);   chk("mid_count0", cnt[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      wlog.delete();
      cmd_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_ready", rdy[0], 0);
      chk("idle_hold", hold[0], 0);
      got_q.delete();
      foreach (wlog[j]) if (wlog[j].k == 0) got_q.push_back(wlog[j]);
      chk("idle_writes", got_q.size(), 0);
      cmd_valid = 1'b0;

      // Random sessions checked against the model.
      for (int s = 0; s < 12; s++) begin
         int   t, dep, fil, m;
         bit   nolast, exp_err;
         cmd_t c;
         t   = s % 3;
         dep = (t == 0) ? 256 : (t == 1) ? 8 : 4;
         fil = (t == 1) ? 1 : 0;
         m   = (t == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, dep));
         if (t == 0 && s == 9) m = 256;
         nolast  = (m == dep) && ($urandom % 2 == 1);
         exp_err = nolast;
         exp_q.delete();
         do_reset();
         do_start();
         for (int i = 0; i < m; i++) begin
            c.kind = int'($urandom % 4);
            c.op = int'($urandom % 8); c.a = int'($urandom % 8);
            c.b = int'($urandom % 8);  c.d = int'($urandom % 8);
            c.imm = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 64);
            if (c.kind == 2 && c.imm >= 64) exp_err = 1'b1;
            exp_q.push_back('{k: t, a: i, d: ref_word(c)});
            repeat ($urandom % 3) @(negedge clk);
            send(t, c, (i == m - 1) && !nolast, ok);
         end
         if (!nolast && fil != 0)
            for (int a = m; a < dep; a++) exp_q.push_back('{k: t, a: a, d: 5632});
         wait_done(t, 300);
         compare_log(t);
         chk("rnd_count", cnt[t], m);
         chk("rnd_err", err[t], exp_err);
         chk("rnd_hold", hold[t], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
